rf_writeback_queue: RTL and testbench

// - Write-back buffer directly upstream of the register file write port (we/addr_rd/data_in).
// - Producers push (addr, data) write requests with a valid/ready handshake.
// - Requests drain in order, at most one per cycle, into the register file write port.
// - Also reports whether a pending, not-yet-committed write targets either read address,
//   so the consumer can forward the newest value.

---
 rtl/rf_writeback_queue.sv | 137 +++++++++++++
 tb/tb_rf_writeback_queue.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rf_writeback_queue: in-order write-back FIFO feeding the register file   |
// | write port, with newest-value lookup for two read addresses.             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rf_writeback_queue #(
  parameter int N     = 4,
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [N-1:0]               i_in_addr,
  input  logic [W-1:0]               i_in_data,
  input  logic                       i_stall,
  output logic                       o_rf_we,
  output logic [N-1:0]               o_rf_addr,
  output logic [W-1:0]               o_rf_data,
  input  logic [N-1:0]               i_q_addr1,
  input  logic [N-1:0]               i_q_addr2,
  output logic                       o_hit1,
  output logic                       o_hit2,
  output logic [W-1:0]               o_hit_data1,
  output logic [W-1:0]               o_hit_data2,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [N-1:0]  r_addr [DEPTH];
  logic [W-1:0]  r_data [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_rf_we;
  logic [N-1:0]  r_rf_addr;
  logic [W-1:0]  r_rf_data;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign o_in_ready = !w_full && !rst;
  // Writes to r0 complete the handshake but are discarded.
  assign w_push     = i_in_valid && o_in_ready && (i_in_addr != '0);
  assign w_pop      = !w_empty && !i_stall;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wptr] <= i_in_addr;
      r_data[r_wptr] <= i_in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_rf_we   <= 1'b0;
      r_rf_addr <= '0;
      r_rf_data <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_rf_we <= w_pop;
      if (w_pop) begin
        r_rf_addr <= r_addr[r_rptr];
        r_rf_data <= r_data[r_rptr];
      end
    end
  end

  // Scan oldest-to-newest so later matches override earlier ones.
  always_comb begin
    logic [AW-1:0] w_idx;
    w_idx       = '0;
    o_hit1      = 1'b0;
    o_hit2      = 1'b0;
    o_hit_data1 = '0;
    o_hit_data2 = '0;
    if (r_rf_we) begin
      if (r_rf_addr == i_q_addr1) begin
        o_hit1      = 1'b1;
        o_hit_data1 = r_rf_data;
      end
      if (r_rf_addr == i_q_addr2) begin
        o_hit2      = 1'b1;
        o_hit_data2 = r_rf_data;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rptr + AW'(i);
      if (CW'(i) < r_count) begin
        if (r_addr[w_idx] == i_q_addr1) begin
          o_hit1      = 1'b1;
          o_hit_data1 = r_data[w_idx];
        end
        if (r_addr[w_idx] == i_q_addr2) begin
          o_hit2      = 1'b1;
          o_hit_data2 = r_data[w_idx];
        end
      end
    end
    if (i_q_addr1 == '0) begin
      o_hit1      = 1'b0;
      o_hit_data1 = '0;
    end
    if (i_q_addr2 == '0) begin
      o_hit2      = 1'b0;
      o_hit_data2 = '0;
    end
  end

  assign o_rf_we   = r_rf_we;
  assign o_rf_addr = r_rf_addr;
  assign o_rf_data = r_rf_data;
  assign o_count   = r_count;
  assign o_empty   = w_empty;
  assign o_full    = w_full;

endmodule
`default_nettype wire

// File: tb/tb_rf_writeback_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rf_writeback_queue: directed bench with a queue scoreboard.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rf_writeback_queue;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [N-1:0] a;
    logic [W-1:0] d;
  } ent_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [N-1:0]          in_addr = '0;
  logic [W-1:0]          in_data = '0;
  logic                  stall = 1'b0;
  logic                  rf_we;
  logic [N-1:0]          rf_addr;
  logic [W-1:0]          rf_data;
  logic [N-1:0]          q_addr1 = '0;
  logic [N-1:0]          q_addr2 = '0;
  logic                  hit1, hit2;
  logic [W-1:0]          hit_data1, hit_data2;
  logic [$clog2(DEPTH):0] count;
  logic                  empty, full;

  int   n_cmp = 0;
  int   n_err = 0;
  ent_t sb[$];
  int   exp_count = 0;
  logic exp_we = 1'b0;
  ent_t exp_out = '0;

  rf_writeback_queue #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_addr(in_addr), .i_in_data(in_data), .i_stall(stall),
    .o_rf_we(rf_we), .o_rf_addr(rf_addr), .o_rf_data(rf_data),
    .i_q_addr1(q_addr1), .i_q_addr2(q_addr2),
    .o_hit1(hit1), .o_hit2(hit2),
    .o_hit_data1(hit_data1), .o_hit_data2(hit_data2),
    .o_count(count), .o_empty(empty), .o_full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Newest pending value: queue back first, then older entries, then output register.
  task automatic model_lookup(input logic [N-1:0] q, output logic h, output logic [W-1:0] d);
    h = 1'b0;
    d = '0;
    if (q != '0) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (!h && sb[i].a == q) begin
          h = 1'b1;
          d = sb[i].d;
        end
      end
      if (!h && exp_we && exp_out.a == q) begin
        h = 1'b1;
        d = exp_out.d;
      end
    end
  endtask

  task automatic check_all();
    logic           h1, h2;
    logic [W-1:0]   d1, d2;
    model_lookup(q_addr1, h1, d1);
    model_lookup(q_addr2, h2, d2);
    chk("count",     32'(count),     32'(exp_count));
    chk("empty",     32'(empty),     32'(exp_count == 0));
    chk("full",      32'(full),      32'(exp_count == DEPTH));
    chk("in_ready",  32'(in_ready),  32'(exp_count != DEPTH));
    chk("rf_we",     32'(rf_we),     32'(exp_we));
    chk("rf_addr",   32'(rf_addr),   32'(exp_out.a));
    chk("rf_data",   32'(rf_data),   32'(exp_out.d));
    chk("hit1",      32'(hit1),      32'(h1));
    chk("hit_data1", 32'(hit_data1), 32'(d1));
    chk("hit2",      32'(hit2),      32'(h2));
    chk("hit_data2", 32'(hit_data2), 32'(d2));
  endtask

  task automatic tick();
    logic acc, pop;
    ent_t e;
    acc = in_valid && (exp_count < DEPTH);
    pop = (exp_count > 0) && !stall;
    e.a = in_addr;
    e.d = in_data;
    @(posedge clk);
    if (pop) begin
      exp_out = sb.pop_front();
      exp_we  = 1'b1;
      exp_count--;
    end else begin
      exp_we = 1'b0;
    end
    if (acc && e.a != '0) begin
      sb.push_back(e);
      exp_count++;
    end
    #1;
    check_all();
  endtask

  task automatic push(input logic [N-1:0] a, input logic [W-1:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset held for two edges
    @(posedge clk); @(posedge clk); #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // r0 filter
    in_valid = 1'b1; in_addr = 4'd0; in_data = 16'hABCD;
    #1;
    chk("r0_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("r0_count", 32'(count), 0);
    tick(); tick();

    // Order and latency
    push(4'd1, 16'h1234);
    push(4'd2, 16'h5678);
    chk("lat1_we", 32'(rf_we), 1);
    chk("lat1_addr", 32'(rf_addr), 1);
    chk("lat1_data", 32'(rf_data), 32'h1234);
    tick();
    chk("lat2_addr", 32'(rf_addr), 2);
    chk("lat2_data", 32'(rf_data), 32'h5678);
    tick(); tick();

    // Fill while stalled, refuse fifth push, drain, then wrap
    stall = 1'b1;
    push(4'd3, 16'hAAAA);
    push(4'd4, 16'hBBBB);
    push(4'd5, 16'hCCCC);
    push(4'd6, 16'hDDDD);
    chk("full_flag", 32'(full), 1);
    chk("full_in_ready", 32'(in_ready), 0);
    push(4'd7, 16'hEEEE);
    chk("refused_count", 32'(count), 4);
    stall = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    push(4'd8, 16'h0808);
    push(4'd9, 16'h0909);
    push(4'd10, 16'h0A0A);
    push(4'd11, 16'h0B0B);
    for (int i = 0; i < 3; i++) tick();

    // Forwarding of the newest pending value
    stall = 1'b1;
    q_addr1 = 4'd7;
    q_addr2 = 4'd8;
    push(4'd7, 16'h1111);
    push(4'd7, 16'h2222);
    chk("fwd_hit1", 32'(hit1), 1);
    chk("fwd_hit_data1", 32'(hit_data1), 32'h2222);
    chk("fwd_hit2", 32'(hit2), 0);
    chk("fwd_hit_data2", 32'(hit_data2), 0);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("fwd_drained_hit1", 32'(hit1), 0);

    // Asynchronous reset mid-drain
    stall = 1'b1;
    q_addr1 = 4'd3;
    q_addr2 = 4'd1;
    push(4'd1, 16'h0001);
    push(4'd2, 16'h0002);
    push(4'd3, 16'h0003);
    push(4'd4, 16'h0004);
    stall = 1'b0;
    tick();
    chk("mid_we", 32'(rf_we), 1);
    chk("mid_count", 32'(count), 3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_rf_we", 32'(rf_we), 0);
    chk("arst_hit1", 32'(hit1), 0);
    chk("arst_hit2", 32'(hit2), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    sb.delete();
    exp_count = 0;
    exp_we    = 1'b0;
    exp_out   = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
